ps2_key_serializer: RTL and testbench
=====================================

Name: ps2_key_serializer

Overview:
- Converts the hps_io keyboard event word `ps2_key[10:0]` into a device-side PS/2 serial stream (`ps2_clk`/`ps2_data`) for the pc8001m core's PS/2 inputs.
- Sits directly upstream of pc8001m, fed by hps_io, running on clk_sys.
- Expands each event into its set-2 byte sequence (E0/F0 prefixes), buffers the bytes in a FIFO and frames each one as an 11-bit PS/2 packet at about 12.5 kHz.

Parameters:
- HALF_DIV, 1146, clk_sys cycles per PS/2 half bit period (28.636 MHz / 25 kHz).
- GAP_HALVES, 8, idle half-periods (clk=1, data=1) inserted after each frame.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, minimum 4.

Ports:
- clk_sys  in  1  system clock, about 28.636 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_key  in  11  [10] toggle strobe, [9] pressed, [8] extended, [7:0] set-2 scancode.
- enable  in  1  0 = new events are discarded; a frame already in progress completes.
- ps2_clk  out  1  PS/2 clock to the core; idle high.
- ps2_data  out  1  PS/2 data to the core; idle high.
- busy  out  1  high while the FIFO is non-empty or a frame or gap is active.
- overflow  out  1  one-cycle pulse when an event is dropped for lack of FIFO space.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert internally):
  - ps2_clk=1, ps2_data=1, busy=0, overflow=0, fifo_level=0.
  - FIFO is flushed and the serializer returns to IDLE.
  - A reset asserted mid-frame returns both lines high immediately.
- Arming:
  - On the first clk_sys edge after reset deasserts, `ps2_key[10]` is copied into `tog_prev` and nothing is enqueued.
  - This prevents a spurious event when the strobe is already 1 at reset.
- Event detect: an event is pending whenever `ps2_key[10] != tog_prev`.
- Enqueue sequencer (states EQ_IDLE, EQ_E0, EQ_F0, EQ_CODE):
  - In EQ_IDLE with an event pending, the whole event is accepted or rejected in one cycle.
  - Accept requires enable=1 and free entries ≥ 3.
  - On accept: latch the event, set `tog_prev` to the new toggle value, then write one byte per cycle.
    - E0 only if extended=1.
    - F0 only if pressed=0.
    - Then the scancode.
  - The sequencer returns to EQ_IDLE after the code byte; events take 1–3 write cycles.
  - If enable=0: `tog_prev` is updated and the event is discarded, with no overflow pulse.
  - If free entries < 3: the whole event is discarded, `tog_prev` is updated and overflow pulses for one cycle.
  - A toggle change arriving while the sequencer is busy stays pending and is handled on return to EQ_IDLE; it is not lost.
- FIFO:
  - Synchronous, one write port and one read port.
  - Simultaneous push and pop are allowed; fifo_level is unchanged in that case.
  - Pointers wrap modulo FIFO_DEPTH.
  - Read data is valid in the cycle after pop.
- Serializer (states S_IDLE, S_LOAD, S_HI, S_LO, S_GAP):
  - S_IDLE: when the FIFO is non-empty, pop and go to S_LOAD.
  - S_LOAD: build an 11-bit frame: start 0, data LSB first, odd parity (`~^byte`), stop 1. Set bit index to 0.
  - S_HI: ps2_clk=1, ps2_data=frame[idx], held for HALF_DIV cycles.
  - S_LO: ps2_clk=0, data unchanged, held for HALF_DIV cycles.
    - The core samples data on the falling edge.
    - After S_LO, increment idx; if idx<11 go to S_HI, else go to S_GAP.
  - S_GAP: ps2_clk=1, ps2_data=1 for GAP_HALVES×HALF_DIV cycles, then go to S_IDLE.
  - Data changes only while ps2_clk is high.
  - One frame lasts 22×HALF_DIV cycles.
- Latency: from a toggle change to the ps2_data falling edge (start bit) is at most 6 clk_sys cycles when the serializer is idle.
- Width rules:
  - Half-period counter width is $clog2(HALF_DIV×GAP_HALVES)+1.
  - fifo_level is one bit wider than the pointers so the full condition is distinguishable from empty.

Decomposition:
- Package `pc8001m_ps2_pkg`:
  - Constants PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, PS2_FRAME_BITS=11.
  - Typedef enums for the enqueue states and serializer states.
  - Function `ps2_frame(byte) -> [10:0]`.
- Sub-module `ps2_byte_fifo` (parameter DEPTH): push/pop/full/empty/level.
- The top level holds the event decode, enqueue sequencer and serializer.

Test Plan:
- Toggle 0→1 with key=11'h1_1C (pressed, 'A') → one frame; data bits seen at falling edges = 0,0,0,1,1,1,0,0,0,0,1 (parity 0); line idle afterwards; frame length 22×HALF_DIV cycles.
- Release of extended Right-Arrow, key={tog,0,1,8'h74} → three frames E0, F0, 74 in order, each followed by GAP_HALVES×HALF_DIV cycles of idle; the final stop bit goes 1→idle with no glitch.
- Six events toggled back-to-back (one every 4 cycles) with FIFO_DEPTH=16 → fifo_level peaks at the correct count and every event serializes in order.
  - With FIFO_DEPTH=4, events that leave fewer than 3 free entries are dropped whole and overflow pulses once per dropped event.
- reset_n deasserted while ps2_key[10]=1 → no frame; a subsequent toggle to 0 → exactly one frame.
- reset_n asserted during S_LO of bit 5 → ps2_clk=1, ps2_data=1 asynchronously, fifo_level=0, no residual frame after release.
- enable=0 while toggling an event → no frame, no overflow.
  - enable dropped mid-frame → the current frame completes and later events are discarded.

Source files
------------

// File: rtl/pc8001m_ps2_pkg.sv
// Shared constants, state encodings and frame builder for the PS/2 key serializer.
package pc8001m_ps2_pkg;

  localparam logic [7:0]  PS2_PFX_EXT    = 8'hE0;
  localparam logic [7:0]  PS2_PFX_BRK    = 8'hF0;
  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    EQ_IDLE,
    EQ_E0,
    EQ_F0,
    EQ_CODE
  } eq_state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HI,
    S_LO,
    S_GAP
  } ser_state_t;

  // Bit 0 is sent first: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Byte FIFO with registered read data (valid the cycle after pop) and occupancy count.
module ps2_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_wdata,
  input  logic                     i_pop,
  output logic [7:0]               o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic [7:0]    r_rdata;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == LVL_FULL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_rdata;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_rdata <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop) begin
        r_rdata <= r_mem[r_rptr];
        r_rptr  <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_serializer.sv
// Turns hps_io ps2_key toggle events into set-2 byte sequences and a device-side
// PS/2 clock/data stream for the pc8001m core.
module ps2_key_serializer
  import pc8001m_ps2_pkg::*;
#(
  parameter int unsigned HALF_DIV   = 1146,
  parameter int unsigned GAP_HALVES = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk_sys,
  input  logic                          reset_n,
  input  logic [10:0]                   ps2_key,
  input  logic                          enable,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(HALF_DIV * GAP_HALVES) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(HALF_DIV * GAP_HALVES - 1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]    IDX_LAST  = 4'(PS2_FRAME_BITS - 1);

  // Assertion is asynchronous; release is re-timed so every flop leaves reset together.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic [7:0] w_rdata;
  logic       w_full;
  logic       w_empty;
  logic [AW:0] w_level;
  logic       w_push;
  logic [7:0] w_wdata;
  logic       w_pop;

  eq_state_t  r_eq;
  logic       r_armed;
  logic       r_tog_prev;
  logic       r_brk;
  logic [7:0] r_code;
  logic       r_overflow;
  logic       w_pending;
  logic       w_room;
  logic [AW:0] w_free;

  assign w_pending = r_armed && (ps2_key[10] != r_tog_prev);
  assign w_free    = LVL_FULL - w_level;
  assign w_room    = (w_free >= (AW+1)'(3));
  assign w_push    = (r_eq != EQ_IDLE) && !w_full;

  always_comb begin
    w_wdata = r_code;
    case (r_eq)
      EQ_E0:   w_wdata = PS2_PFX_EXT;
      EQ_F0:   w_wdata = PS2_PFX_BRK;
      default: w_wdata = r_code;
    endcase
  end

  // A whole event is accepted or dropped at once so a make/break never splits.
  always_ff @(posedge clk_sys or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_eq       <= EQ_IDLE;
      r_armed    <= 1'b0;
      r_tog_prev <= 1'b0;
      r_brk      <= 1'b0;
      r_code     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (!r_armed) begin
        r_armed    <= 1'b1;
        r_tog_prev <= ps2_key[10];
      end else begin
        case (r_eq)
          EQ_IDLE: begin
            if (w_pending) begin
              r_tog_prev <= ps2_key[10];
              if (enable && w_room) begin
                r_brk  <= !ps2_key[9];
                r_code <= ps2_key[7:0];
                if (ps2_key[8])      r_eq <= EQ_E0;
                else if (!ps2_key[9]) r_eq <= EQ_F0;
                else                 r_eq <= EQ_CODE;
              end else if (enable) begin
                r_overflow <= 1'b1;
              end
            end
          end
          EQ_E0:   r_eq <= r_brk ? EQ_F0 : EQ_CODE;
          EQ_F0:   r_eq <= EQ_CODE;
          EQ_CODE: r_eq <= EQ_IDLE;
          default: r_eq <= EQ_IDLE;
        endcase
      end
    end
  end

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_sys),
    .i_rst_n (w_rst_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  ser_state_t    r_st;
  logic [10:0]   r_frame;
  logic [3:0]    r_idx;
  logic [3:0]    w_idx_next;
  logic [CW-1:0] r_cnt;
  logic          r_clk;
  logic          r_data;
  logic [10:0]   w_frame;

  assign w_pop      = (r_st == S_IDLE) && !w_empty;
  assign w_frame    = ps2_frame(w_rdata);
  assign w_idx_next = r_idx + 4'd1;

  always_ff @(posedge clk_sys or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_st    <= S_IDLE;
      r_frame <= '1;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_clk   <= 1'b1;
      r_data  <= 1'b1;
    end else begin
      case (r_st)
        S_IDLE: begin
          if (!w_empty) r_st <= S_LOAD;
        end
        S_LOAD: begin
          r_frame <= w_frame;
          r_idx   <= '0;
          r_cnt   <= '0;
          r_clk   <= 1'b1;
          r_data  <= w_frame[0];
          r_st    <= S_HI;
        end
        S_HI: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
            r_st  <= S_LO;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LO: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            r_clk <= 1'b1;
            if (r_idx == IDX_LAST) begin
              r_data <= 1'b1;
              r_st   <= S_GAP;
            end else begin
              r_idx  <= w_idx_next;
              r_data <= r_frame[w_idx_next];
              r_st   <= S_HI;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt <= '0;
            r_st  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

  assign ps2_clk    = r_clk;
  assign ps2_data   = r_data;
  assign overflow   = r_overflow;
  assign fifo_level = w_level;
  assign busy       = !w_empty || (r_st != S_IDLE) || (r_eq != EQ_IDLE);

endmodule

// File: tb/tb_ps2_key_serializer.sv
// Bench for ps2_key_serializer: two instances (16- and 4-deep FIFO) with
// frame-decoding monitors checked against queues of expected bytes.
module tb_ps2_key_serializer;

  localparam int unsigned H = 4;
  localparam int unsigned G = 8;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [10:0] key_a, key_b;
  logic        tog_a, tog_b;
  logic        clk_a, dat_a, busy_a, ovf_a;
  logic        clk_b, dat_b, busy_b, ovf_b;
  logic [4:0]  level_a;
  logic [2:0]  level_b;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned cyc = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  int          mon_a_bits = 0, mon_b_bits = 0;
  int          frames_a = 0, frames_b = 0;
  logic [10:0] mon_a_sh, mon_b_sh, last_a;
  int unsigned mon_a_t0, mon_a_end;
  bit          mon_a_prev = 0;
  int          glitch_errs = 0;
  logic        prev_clk_a = 1'b1, prev_dat_a = 1'b1;

  ps2_key_serializer #(.HALF_DIV(H), .GAP_HALVES(G), .FIFO_DEPTH(16)) dut_a (
    .clk_sys(clk), .reset_n(rst_n), .ps2_key(key_a), .enable(en),
    .ps2_clk(clk_a), .ps2_data(dat_a), .busy(busy_a), .overflow(ovf_a),
    .fifo_level(level_a)
  );

  ps2_key_serializer #(.HALF_DIV(H), .GAP_HALVES(G), .FIFO_DEPTH(4)) dut_b (
    .clk_sys(clk), .reset_n(rst_n), .ps2_key(key_b), .enable(en),
    .ps2_clk(clk_b), .ps2_data(dat_b), .busy(busy_b), .overflow(ovf_b),
    .fifo_level(level_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && prev_clk_a === 1'b0 && clk_a === 1'b0 && dat_a !== prev_dat_a)
      glitch_errs++;
    prev_clk_a = clk_a;
    prev_dat_a = dat_a;
  end

  always @(negedge clk_a or negedge rst_n) begin : mon_a
    logic [7:0]  e;
    logic [10:0] ef;
    if (!rst_n) begin
      mon_a_bits = 0;
      mon_a_prev = 0;
    end else begin
      mon_a_sh[mon_a_bits] = dat_a;
      if (mon_a_bits == 0) begin
        mon_a_t0 = cyc;
        if (mon_a_prev) begin
          n_checks++;
          if (mon_a_t0 - mon_a_end >= (G + 2) * H) n_pass++;
          else $display("FAIL gap_a: got %0d cycles want >= %0d", mon_a_t0 - mon_a_end, (G + 2) * H);
        end
      end
      mon_a_bits++;
      if (mon_a_bits == 11) begin
        mon_a_bits = 0;
        frames_a++;
        last_a     = mon_a_sh;
        mon_a_end  = cyc;
        mon_a_prev = 1;
        n_checks++;
        if (mon_a_end - mon_a_t0 == 20 * H) n_pass++;
        else $display("FAIL frame_len_a: got %0d want %0d", mon_a_end - mon_a_t0, 20 * H);
        n_checks++;
        if (exp_a.size() == 0) begin
          $display("FAIL frame_a: got unexpected frame %h", mon_a_sh);
        end else begin
          e  = exp_a.pop_front();
          ef = {1'b1, ~^e, e, 1'b0};
          if (mon_a_sh === ef) n_pass++;
          else $display("FAIL frame_a: got %h want %h", mon_a_sh, ef);
        end
      end
    end
  end

  always @(negedge clk_b or negedge rst_n) begin : mon_b
    logic [7:0]  e;
    logic [10:0] ef;
    if (!rst_n) begin
      mon_b_bits = 0;
    end else begin
      mon_b_sh[mon_b_bits] = dat_b;
      mon_b_bits++;
      if (mon_b_bits == 11) begin
        mon_b_bits = 0;
        frames_b++;
        n_checks++;
        if (exp_b.size() == 0) begin
          $display("FAIL frame_b: got unexpected frame %h", mon_b_sh);
        end else begin
          e  = exp_b.pop_front();
          ef = {1'b1, ~^e, e, 1'b0};
          if (mon_b_sh === ef) n_pass++;
          else $display("FAIL frame_b: got %h want %h", mon_b_sh, ef);
        end
      end
    end
  end

  task automatic send_a(input logic pressed, input logic ext, input logic [7:0] code, input bit expect_it);
    tog_a = ~tog_a;
    key_a = {tog_a, pressed, ext, code};
    if (expect_it) begin
      if (ext)      exp_a.push_back(8'hE0);
      if (!pressed) exp_a.push_back(8'hF0);
      exp_a.push_back(code);
    end
  endtask

  task automatic send_b(input logic pressed, input logic ext, input logic [7:0] code, input bit expect_it);
    tog_b = ~tog_b;
    key_b = {tog_b, pressed, ext, code};
    if (expect_it) begin
      if (ext)      exp_b.push_back(8'hE0);
      if (!pressed) exp_b.push_back(8'hF0);
      exp_b.push_back(code);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy_a || busy_b) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (!busy_a && !busy_b) n_pass++;
    else $display("FAIL drain_timeout: busy_a=%b busy_b=%b want 0 0", busy_a, busy_b);
  endtask

  task automatic test_reset();
    n_checks += 5;
    if (clk_a === 1'b1) n_pass++; else $display("FAIL reset_clk: got %b want 1", clk_a);
    if (dat_a === 1'b1) n_pass++; else $display("FAIL reset_data: got %b want 1", dat_a);
    if (busy_a === 1'b0) n_pass++; else $display("FAIL reset_busy: got %b want 0", busy_a);
    if (ovf_a === 1'b0) n_pass++; else $display("FAIL reset_overflow: got %b want 0", ovf_a);
    if (level_a === 5'd0) n_pass++; else $display("FAIL reset_level: got %0d want 0", level_a);
  endtask

  task automatic test_single_press();
    int n = 0;
    int f0 = frames_a;
    @(negedge clk);
    send_a(1'b1, 1'b0, 8'h1C, 1'b1);
    while (dat_a !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n <= 6) n_pass++; else $display("FAIL latency: got %0d cycles want <= 6", n);
    wait_idle();
    n_checks += 4;
    if (frames_a == f0 + 1) n_pass++; else $display("FAIL press_frames: got %0d want %0d", frames_a - f0, 1);
    if (last_a === 11'h438) n_pass++; else $display("FAIL press_bits: got %h want 438", last_a);
    if (clk_a === 1'b1 && dat_a === 1'b1) n_pass++;
    else $display("FAIL press_idle_lines: got clk=%b data=%b want 1 1", clk_a, dat_a);
    if (exp_a.size() == 0) n_pass++; else $display("FAIL press_missing: got %0d pending want 0", exp_a.size());
  endtask

  task automatic test_ext_release();
    int f0 = frames_a;
    @(negedge clk);
    send_a(1'b0, 1'b1, 8'h74, 1'b1);
    wait_idle();
    n_checks += 3;
    if (frames_a == f0 + 3) n_pass++; else $display("FAIL ext_frames: got %0d want 3", frames_a - f0);
    if (last_a === 11'h6E8) n_pass++; else $display("FAIL ext_last_bits: got %h want 6e8", last_a);
    if (exp_a.size() == 0) n_pass++; else $display("FAIL ext_missing: got %0d pending want 0", exp_a.size());
  endtask

  task automatic test_back_to_back();
    logic       pr [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       ex [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] cd [6] = '{8'h1C, 8'h74, 8'h1C, 8'h74, 8'h32, 8'h21};
    int peak = 0, ovf_cnt = 0;
    int f0 = frames_a;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      send_a(pr[i], ex[i], cd[i], 1'b1);
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        if (int'(level_a) > peak) peak = int'(level_a);
        if (ovf_a) ovf_cnt++;
      end
    end
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (int'(level_a) > peak) peak = int'(level_a);
    end
    n_checks += 2;
    if (peak == 9) n_pass++; else $display("FAIL b2b_peak_level: got %0d want 9", peak);
    if (ovf_cnt == 0) n_pass++; else $display("FAIL b2b_overflow: got %0d want 0", ovf_cnt);
    wait_idle();
    n_checks += 2;
    if (frames_a == f0 + 10) n_pass++; else $display("FAIL b2b_frames: got %0d want 10", frames_a - f0);
    if (exp_a.size() == 0) n_pass++; else $display("FAIL b2b_missing: got %0d pending want 0", exp_a.size());
  endtask

  task automatic test_overflow();
    int peak = 0, ovf_cnt = 0;
    int f0 = frames_b;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      send_b(1'b1, 1'b0, 8'h1C, 1'b1);
      else if (i == 1) send_b(1'b0, 1'b1, 8'h74, 1'b1);
      else             send_b(i[0], 1'b0, 8'h15 + 8'(i), 1'b0);
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        if (int'(level_b) > peak) peak = int'(level_b);
        if (ovf_b) ovf_cnt++;
      end
    end
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (ovf_b) ovf_cnt++;
    end
    n_checks += 2;
    if (ovf_cnt == 4) n_pass++; else $display("FAIL ovf_pulses: got %0d want 4", ovf_cnt);
    if (peak == 3) n_pass++; else $display("FAIL ovf_peak_level: got %0d want 3", peak);
    wait_idle();
    n_checks += 2;
    if (frames_b == f0 + 4) n_pass++; else $display("FAIL ovf_frames: got %0d want 4", frames_b - f0);
    if (exp_b.size() == 0) n_pass++; else $display("FAIL ovf_missing: got %0d pending want 0", exp_b.size());
  endtask

  task automatic test_reset_armed();
    int f0;
    @(negedge clk);
    rst_n = 1'b0;
    tog_a = 1'b1;
    key_a = {1'b1, 1'b1, 1'b0, 8'h1C};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    f0 = frames_a;
    repeat (40) @(negedge clk);
    n_checks += 2;
    if (frames_a == f0) n_pass++; else $display("FAIL armed_spurious: got %0d frames want 0", frames_a - f0);
    if (busy_a === 1'b0) n_pass++; else $display("FAIL armed_busy: got %b want 0", busy_a);
    send_a(1'b1, 1'b0, 8'h1C, 1'b1);
    wait_idle();
    n_checks++;
    if (frames_a == f0 + 1) n_pass++; else $display("FAIL armed_frames: got %0d want 1", frames_a - f0);
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    int f0;
    @(negedge clk);
    send_a(1'b0, 1'b1, 8'h74, 1'b1);
    while (mon_a_bits != 6 && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (clk_a === 1'b0) n_pass++; else $display("FAIL midreset_pre_clk: got %b want 0", clk_a);
    rst_n = 1'b0;
    exp_a.delete();
    #1;
    n_checks += 3;
    if (clk_a === 1'b1 && dat_a === 1'b1) n_pass++;
    else $display("FAIL midreset_lines: got clk=%b data=%b want 1 1", clk_a, dat_a);
    if (level_a === 5'd0) n_pass++; else $display("FAIL midreset_level: got %0d want 0", level_a);
    if (busy_a === 1'b0) n_pass++; else $display("FAIL midreset_busy: got %b want 0", busy_a);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    f0 = frames_a;
    repeat (300) @(negedge clk);
    n_checks++;
    if (frames_a == f0 && mon_a_bits == 0) n_pass++;
    else $display("FAIL midreset_residual: got frames=%0d bits=%0d want 0 0", frames_a - f0, mon_a_bits);
  endtask

  task automatic test_enable();
    int ovf_cnt = 0, n = 0;
    int f0 = frames_a;
    @(negedge clk);
    en = 1'b0;
    send_a(1'b1, 1'b0, 8'h1C, 1'b0);
    for (int j = 0; j < 150; j++) begin
      @(negedge clk);
      if (ovf_a) ovf_cnt++;
    end
    n_checks += 3;
    if (frames_a == f0) n_pass++; else $display("FAIL dis_frames: got %0d want 0", frames_a - f0);
    if (ovf_cnt == 0) n_pass++; else $display("FAIL dis_overflow: got %0d want 0", ovf_cnt);
    if (level_a === 5'd0 && busy_a === 1'b0) n_pass++;
    else $display("FAIL dis_idle: got level=%0d busy=%b want 0 0", level_a, busy_a);
    en = 1'b1;
    send_a(1'b1, 1'b0, 8'h32, 1'b1);
    while (mon_a_bits < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    en = 1'b0;
    send_a(1'b1, 1'b0, 8'h21, 1'b0);
    wait_idle();
    n_checks += 2;
    if (frames_a == f0 + 1) n_pass++; else $display("FAIL midframe_dis_frames: got %0d want 1", frames_a - f0);
    if (exp_a.size() == 0) n_pass++; else $display("FAIL midframe_dis_missing: got %0d want 0", exp_a.size());
    en = 1'b1;
  endtask

  task automatic test_line_discipline();
    n_checks++;
    if (glitch_errs == 0) n_pass++;
    else $display("FAIL data_while_clk_low: got %0d changes want 0", glitch_errs);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    tog_a = 1'b0;
    tog_b = 1'b0;
    key_a = '0;
    key_b = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    test_reset();
    test_single_press();
    test_ext_release();
    test_back_to_back();
    test_overflow();
    test_reset_armed();
    test_reset_midframe();
    test_enable();
    test_line_discipline();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
